// File: rtl/lsu_mem_ctrl_pkg.sv
// rtl/lsu_mem_ctrl_pkg.sv - shared size encodings, FSM states and alignment helper
package lsu_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // True when the access cannot be served: illegal size or lane straddles a word
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - request/response and memory-port bundle of the LSU memory controller
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_enable;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic              mem_err;

    // Controller view
    modport slave (
        input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_ready, mem_rdata, mem_ready, mem_err,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_enable, mem_wr, mem_addr, mem_wdata
    );

    // Environment view: pipeline stage plus memory
    modport master (
        output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_ready, mem_rdata, mem_ready, mem_err,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_enable, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - sub-word load extract/extend and store merge, purely combinational
module mem_lane_align
    import lsu_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata[{offset, 3'b000} +: 8];
    assign half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

    // Load path: select the addressed lane and sign- or zero-extend it
    always_comb begin
        load_data = rdata;
        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
            SZ_HALF: load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
            default: load_data = rdata;
        endcase
    end

    // Store path: overwrite only the addressed lane(s) of the old word
    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: merged[{offset, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (offset[1]) merged[31:16] = wdata[15:0];
                else           merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store controller driving a stalling single-port 32-bit memory
module lsu_mem_ctrl
    import lsu_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    lsu_mem_ctrl_if.slave bus
);
    state_t            state;
    logic              wr_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [31:0]       load_data;
    logic [31:0]       merged;

    mem_lane_align u_align (
        .rdata       (bus.mem_rdata),
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .old_word    (bus.mem_rdata),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    // All outputs decode registered state only, so nothing on req_* reaches the memory port combinationally
    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.mem_enable = (state == ST_RD) || (state == ST_WR);
    assign bus.mem_wr     = (state == ST_WR);
    assign bus.mem_addr   = bus.mem_enable ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus.mem_wdata  = (state == ST_WR) ? wdata_q : '0;
    assign bus.rsp_valid  = (state == ST_RESP);
    assign bus.rsp_rdata  = (state == ST_RESP) ? rdata_q : '0;
    assign bus.rsp_err    = (state == ST_RESP) && err_q;

    // Control FSM with request capture; wdata_q is reused to hold the merged RMW word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            wr_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        wr_q    <= bus.req_wr;
                        size_q  <= bus.req_size;
                        uns_q   <= bus.req_unsigned;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        if (misaligned(bus.req_size, bus.req_addr[1:0])) begin
                            err_q <= 1'b1;
                            state <= ST_RESP;
                        end else if (bus.req_wr && bus.req_size == SZ_WORD) begin
                            state <= ST_WR;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (bus.mem_ready) begin
                        if (bus.mem_err) begin
                            err_q <= 1'b1;
                            state <= ST_RESP;
                        end else if (wr_q) begin
                            wdata_q <= merged;
                            state   <= ST_WR;
                        end else begin
                            rdata_q <= load_data;
                            state   <= ST_RESP;
                        end
                    end
                end
                ST_WR: begin
                    if (bus.mem_ready) begin
                        err_q <= bus.mem_err;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - randomized self-checking bench for lsu_mem_ctrl against a behavioural model
module tb_lsu_mem_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if #(.ADDR_W(32)) bus ();
    lsu_mem_ctrl #(.ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [32];
    logic [31:0] ref_mem [32];

    int  p_rd_stall, p_wr_stall;
    bit  p_rd_err, p_wr_err;

    bit          cur_active = 0;
    logic [31:0] e_addr, e_wword, e_rdata;
    bit          e_err, e_read, e_write;
    int          rd_cyc, wr_cyc;

    bit          w_go = 0;
    logic [4:0]  w_idx;
    logic [31:0] w_data;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic abort(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out", name);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_ext(input logic [31:0] w, input int off, input int nb, input bit uns);
        longint m, v;
        if (nb == 4) return w;
        m = longint'(1) << (8 * nb);
        v = longint'(w >> (8 * off)) % m;
        if (!uns && v >= m / 2) v = v - m;
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] wd, input int off, input int nb);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++)
            if (k >= off && k < off + nb) r[8*k +: 8] = wd[8*(k-off) +: 8];
        return r;
    endfunction

    // Memory responder: stalls each phase by the planned count, then completes
    initial begin
        int  cnt;
        bit  prev_en, prev_wr;
        int  stall;
        cnt = 0; prev_en = 0; prev_wr = 0;
        bus.mem_ready = 0; bus.mem_err = 0; bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            w_go = 0;
            if (bus.mem_enable) begin
                if (!prev_en || prev_wr != bus.mem_wr) cnt = 0;
                stall = bus.mem_wr ? p_wr_stall : p_rd_stall;
                bus.mem_ready = (cnt >= stall);
                bus.mem_err   = bus.mem_ready && (bus.mem_wr ? p_wr_err : p_rd_err);
                bus.mem_rdata = mem[bus.mem_addr[6:2]];
                cnt++;
                if (bus.mem_wr && bus.mem_ready && !bus.mem_err) begin
                    w_go = 1; w_idx = bus.mem_addr[6:2]; w_data = bus.mem_wdata;
                end
            end else begin
                bus.mem_ready = ($urandom_range(0, 3) == 0);
                bus.mem_err   = 1'($urandom_range(0, 1));
                bus.mem_rdata = $urandom;
            end
            prev_en = bus.mem_enable;
            prev_wr = bus.mem_wr;
        end
    end

    // Memory array update on the completing edge
    initial forever begin
        @(posedge clk);
        if (w_go && rst_n) mem[w_idx] = w_data;
    end

    // Per-cycle comparison of DUT outputs against the current transaction's expectations
    initial forever begin
        @(negedge clk);
        chk("mem_addr_lo", {30'd0, bus.mem_addr[1:0]}, 32'd0);
        if (cur_active) begin
            chk("req_ready_busy", {31'd0, bus.req_ready}, 32'd0);
            if (bus.mem_enable) begin
                chk("mem_addr", bus.mem_addr, e_addr);
                if (bus.mem_wr) begin
                    chk("write_expected", 32'd1, {31'd0, e_write});
                    chk("mem_wdata", bus.mem_wdata, e_wword);
                    wr_cyc++;
                end else begin
                    chk("read_expected", 32'd1, {31'd0, e_read});
                    rd_cyc++;
                end
            end
            if (bus.rsp_valid) begin
                chk("rsp_rdata", bus.rsp_rdata, e_rdata);
                chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e_err});
            end
        end else begin
            chk("idle_flags", {28'd0, bus.req_ready, bus.mem_enable, bus.rsp_valid, bus.mem_wr}, 32'h8);
            chk("idle_mem_bus", bus.mem_addr | bus.mem_wdata, 32'd0);
        end
    end

    task automatic run(input bit wr, input logic [1:0] size, input bit uns, input logic [31:0] addr,
                       input logic [31:0] wdata, input int rs, input bit re, input int ws, input bit we,
                       input int hold, output logic [31:0] got_rdata, output bit got_err, output int lat);
        int nb, off, idx, exp_lat;
        bit mis;
        nb  = nbytes(size);
        off = int'(addr[1:0]);
        idx = int'(addr[6:2]);
        mis = (size == 2'd3) || (addr % nb != 0);
        e_read  = !mis && (!wr || size != 2'd2);
        e_write = !mis && wr && !(e_read && re);
        e_err   = mis || (e_read && re) || (e_write && we);
        e_addr  = addr & ~32'd3;
        e_wword = (size == 2'd2) ? wdata : model_merge(ref_mem[idx], wdata, off, nb);
        e_rdata = (!wr && !e_err) ? model_ext(ref_mem[idx], off, nb, uns) : 32'd0;
        exp_lat = mis ? 1 : (e_read ? rs + 1 : 0) + (e_write ? ws + 1 : 0) + 1;
        if (e_write && !we) ref_mem[idx] = e_wword;
        p_rd_stall = rs; p_rd_err = re; p_wr_stall = ws; p_wr_err = we;

        @(negedge clk);
        bus.req_valid = 1; bus.req_wr = wr; bus.req_size = size; bus.req_unsigned = uns;
        bus.req_addr = addr; bus.req_wdata = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 0; bus.req_addr = $urandom; bus.req_wdata = $urandom;
        rd_cyc = 0; wr_cyc = 0; cur_active = 1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat > 200) abort("rsp_wait");
        end while (!bus.rsp_valid);
        got_rdata = bus.rsp_rdata;
        got_err   = bus.rsp_err;
        chk("latency", lat, exp_lat);
        chk("read_cycles", rd_cyc, e_read ? rs + 1 : 0);
        chk("write_cycles", wr_cyc, e_write ? ws + 1 : 0);
        repeat (hold) @(negedge clk);
        bus.rsp_ready = 1;
        // a legal load offered during the response handshake must not be taken
        bus.req_valid = 1; bus.req_wr = 0; bus.req_size = 2'd2; bus.req_addr = 32'h0;
        @(posedge clk);
        #1;
        bus.rsp_ready = 0; bus.req_valid = 0; cur_active = 0;
    endtask

    initial begin
        logic [31:0] r;
        bit          e;
        int          l;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] old;
        int          n;

        bus.req_valid = 0; bus.req_wr = 0; bus.req_size = 0; bus.req_unsigned = 0;
        bus.req_addr = 0; bus.req_wdata = 0; bus.rsp_ready = 0;
        p_rd_stall = 0; p_wr_stall = 0; p_rd_err = 0; p_wr_err = 0;
        for (int i = 0; i < 32; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end

        #2 rst_n = 0;
        #1;
        chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("reset_others", {29'd0, bus.mem_enable, bus.rsp_valid, bus.rsp_err} | bus.mem_addr
                            | bus.mem_wdata | bus.rsp_rdata | {31'd0, bus.mem_wr}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        mem[4] = 32'hDEAD_BEEF; ref_mem[4] = mem[4];
        run(0, 2'd2, 0, 32'h10, 32'h0, 3, 0, 0, 0, 0, r, e, l);
        chk("lw_data", r, 32'hDEAD_BEEF); chk("lw_err", {31'd0, e}, 32'd0); chk("lw_lat", l, 5);

        mem[4] = 32'h8011_2233; ref_mem[4] = mem[4];
        run(0, 2'd0, 0, 32'h13, 32'h0, 0, 0, 0, 0, 0, r, e, l);
        chk("lb_data", r, 32'hFFFF_FF80);
        run(0, 2'd0, 1, 32'h13, 32'h0, 0, 0, 0, 0, 1, r, e, l);
        chk("lbu_data", r, 32'h0000_0080);
        run(0, 2'd1, 0, 32'h12, 32'h0, 1, 0, 0, 0, 0, r, e, l);
        chk("lh_data", r, 32'hFFFF_8011);

        mem[8] = 32'h1122_3344; ref_mem[8] = mem[8];
        run(1, 2'd0, 0, 32'h21, 32'h1234_56AB, 0, 0, 0, 0, 0, r, e, l);
        chk("sb_word", mem[8], 32'h1122_AB44); chk("sb_lat", l, 3); chk("sb_rdata", r, 32'd0);

        run(0, 2'd2, 0, 32'h06, 32'h0, 0, 0, 0, 0, 0, r, e, l);
        chk("lw_mis_err", {31'd0, e}, 32'd1); chk("lw_mis_lat", l, 1);
        run(1, 2'd1, 0, 32'h03, 32'hFFFF, 0, 0, 0, 0, 0, r, e, l);
        chk("sh_mis_err", {31'd0, e}, 32'd1);
        run(0, 2'd3, 0, 32'h00, 32'h0, 0, 0, 0, 0, 0, r, e, l);
        chk("ill_size_err", {31'd0, e}, 32'd1); chk("ill_size_rdata", r, 32'd0);

        old = mem[16];
        run(1, 2'd1, 0, 32'h40, 32'hBEEF, 0, 1, 0, 0, 5, r, e, l);
        chk("rmw_err", {31'd0, e}, 32'd1); chk("rmw_err_lat", l, 2); chk("rmw_err_nowrite", mem[16], old);

        for (int t = 0; t < 150; t++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = $urandom & 32'h0300_007F;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(nbytes(sz)) - 32'd1);
            run(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                $urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0), $urandom_range(0, 2), r, e, l);
        end

        // reset in the middle of a stalled word store
        old = mem[12];
        e_read = 0; e_write = 1; e_err = 0; e_addr = 32'h30; e_wword = 32'h55AA_55AA; e_rdata = 0;
        p_rd_stall = 0; p_rd_err = 0; p_wr_stall = 1000; p_wr_err = 0;
        @(negedge clk);
        bus.req_valid = 1; bus.req_wr = 1; bus.req_size = 2'd2; bus.req_addr = 32'h30;
        bus.req_wdata = 32'h55AA_55AA;
        @(posedge clk);
        #1;
        bus.req_valid = 0; rd_cyc = 0; wr_cyc = 0; cur_active = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n > 20) abort("wr_wait");
        end while (!bus.mem_wr);
        repeat (2) @(negedge clk);
        #2 rst_n = 0;
        #1;
        cur_active = 0;
        chk("rst_mem_enable", {31'd0, bus.mem_enable}, 32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_no_write", mem[12], old);

        run(0, 2'd2, 0, 32'h30, 32'h0, 0, 0, 0, 0, 0, r, e, l);
        chk("post_rst_lw", r, old);

        for (int i = 0; i < 32; i++) chk($sformatf("final_mem_%0d", i), mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Requester-side controller for the stalling single-port memory: accepts load/store requests from the pipeline's memory stage and drives the memory port, holding each access until the memory signals ready. It converts RISC-V byte/half/word accesses into aligned 32-bit memory transactions, using read-modify-write for sub-word stores and extract plus sign/zero-extension for sub-word loads. It sits between the LSU pipeline stage and the data memory instance.

## Interface
- `ADDR_W`, 32, byte-address width of request and memory port
- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept (high only in IDLE)
- `req_wr`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `req_unsigned`  in  1  zero-extend sub-word loads (LBU/LHU)
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  32  store data, right-justified
- `rsp_valid`  out  1  response present; held until `rsp_ready`
- `rsp_ready`  in  1  consumer accepts response
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors
- `rsp_err`  out  1  misaligned, illegal size, or memory error
- `mem_enable`  out  1  memory access request
- `mem_wr`  out  1  memory write
- `mem_addr`  out  ADDR_W  word-aligned address, low two bits always 00
- `mem_wdata`  out  32  write data to memory
- `mem_rdata`  in  32  combinational read data from memory
- `mem_ready`  in  1  access completed this cycle
- `mem_err`  in  1  memory fault, valid only with `mem_ready`

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE: `req_ready`=1. Handshake is `req_valid & req_ready`. It captures wr, size, unsigned, addr, and wdata.
- Alignment check at accept:
  - Half requires `addr[0]`=0. Word requires `addr[1:0]`=00.
  - Size 11 is illegal.
  - A failing request goes to RESP with `rsp_err`=1, `rsp_rdata`=0, and no memory access.
- Load, or sub-word store: go to RD.
  - In RD, `mem_enable`=1, `mem_wr`=0, `mem_addr`={addr[ADDR_W-1:2],00}. Hold until `mem_ready`.
  - On `mem_ready` with `mem_err`: go to RESP with err=1. The RMW write is skipped.
  - On a load with no error: register the extracted lane and go to RESP.
  - On a sub-word store with no error: register the merged word and go to WR.
- Word store: go directly to WR.
  - In WR, `mem_enable`=1, `mem_wr`=1, and `mem_wdata` is the full or merged word. Hold until `mem_ready`, then go to RESP. `rsp_err`=`mem_err`.
- Lanes are little-endian: byte k is bits [8k+7:8k].
  - Byte uses `addr[1:0]`; half uses `addr[1]`.
  - Sign extension takes bit 7 or 15 of the lane unless `req_unsigned`.
  - Merge replaces only the addressed lane(s) with the low bits of wdata.
- `mem_ready` is ignored when `mem_enable`=0.
- RESP: `rsp_valid`=1 until `rsp_ready`, then go to IDLE. A new request cannot be accepted in the same cycle as the response handshake.
- All memory-port outputs are 0 outside RD/WR.

## Timing
- Reset (async assert): state goes to IDLE, `req_ready`=1, and all other outputs are 0.
  - Reset mid-RD or mid-WR drops `mem_enable` immediately. No partial write is possible, because the memory writes only on an edge where it is ready.
- Memory outputs are registered-state decodes with no combinational path from `req_*`. `mem_rdata` is sampled on the edge where `mem_ready`=1.
- Zero-stall latency, from accept edge to first `rsp_valid` cycle:
  - Word load: 2 cycles (RD 1 + RESP).
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Misaligned: 1 cycle.
- Each stall cycle adds 1 cycle. `mem_addr`, `mem_wr`, and `mem_wdata` remain stable across stalls.
- RD goes to WR on consecutive cycles with `mem_enable` held high.
- Throughput is at most one request per (latency + 1) cycles.

## Structure
- Shared package `lsu_mem_pkg` holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum
  - `misaligned(size, addr)` function
- Sub-module `mem_lane_align` is purely combinational. It produces the load extract/extend from (rdata, addr[1:0], size, unsigned) and the store merge from (old, wdata, addr[1:0], size).
- The FSM, capture registers, and response registers live in the top.

## Test plan
- Word load at 0x0000_0010, memory holds 0xDEAD_BEEF, `mem_ready` low 3 cycles → address/enable stable 4 cycles, `rsp_rdata`=0xDEAD_BEEF, err=0, 5 cycles latency.
- LB at 0x13 with word 0x80_11_22_33 → 0xFFFF_FF80. LBU at same address → 0x0000_0080. LH at 0x12 → 0xFFFF_8011.
- SB 0xAB to 0x21, old word 0x1122_3344 → read then write 0x1122_AB44 at 0x20, one write cycle only.
- LW at 0x06, SH at 0x03, and size 11 → `rsp_err`=1 within 1 cycle, `mem_enable` never asserted.
- `mem_err`=1 on the RMW read of SH at 0x40 → no WR cycle, `rsp_err`=1. Separately, `rsp_ready` held low 5 cycles → response stable and `req_ready` stays 0.
- Assert `rst_n` low during a WR stall → `mem_enable`=0 asynchronously, memory word unchanged, `req_ready`=1 after release.
